lsu_wb_master: RTL and testbench
================================

Name: lsu_wb_master

Overview:
- Load/store unit sitting directly downstream of the MEM1 stage.
- Accepts one memory request at a time: address, write-enable, byte selects and pre-formatted write data.
- Runs it as a Wishbone B4 classic single-beat cycle on the data bus.
- Returns raw 32-bit read data with a one-cycle done pulse. MEM1 then formats the read data, and its stall logic relies on done never coinciding with the request cycle.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before forced termination (used only with the optional feature).
- RESET_PC_UNUSED, 0: none; reserved, no function.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- lsu_req_i  in  1  request strobe from MEM1
- lsu_addr_i  in  32  byte address
- lsu_we_i  in  1  1 = store
- lsu_wsel_byte_i  in  4  byte lane enables for stores
- lsu_wdata_i  in  32  lane-aligned store data
- lsu_req_stall_o  out  1  unit busy; requests not accepted
- lsu_rdata_o  out  32  raw read word, valid with done
- lsu_req_done_o  out  1  one-cycle completion pulse
- lsu_err_o  out  1  bus error, valid with done
- lsu_timeout_o  out  1  completion was forced by timeout, valid with done
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  word address, bits [1:0] forced to 0
- wb_sel_o  out  4  byte selects; 4'b1111 for loads
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error termination

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0. State IDLE, timeout counter 0, lsu_rdata_o 0.
- States: IDLE, BUS, RESP.
- IDLE:
  - lsu_req_stall_o = 0.
  - When lsu_req_i = 1, capture addr/we/sel/wdata into registers and go to BUS.
  - Loads register sel = 4'b1111 and wdata = 0.
- BUS:
  - wb_cyc_o = wb_stb_o = 1; all wb_* outputs come from the captured registers.
  - Outputs stay stable until termination.
  - On wb_err_i: lsu_rdata_o <= 0, err flag <= 1, go to RESP.
  - Else on wb_ack_i: lsu_rdata_o <= wb_dat_i for loads (stores leave 0), err <= 0, go to RESP.
  - err wins over a simultaneous ack.
- RESP:
  - cyc/stb = 0; lsu_req_done_o = 1 for exactly this cycle; lsu_err_o/lsu_timeout_o valid; go to IDLE.
  - lsu_rdata_o holds its value until the next termination.
- lsu_req_stall_o = 1 in BUS and RESP.
- Latency: request at cycle N, cyc/stb at N+1, ack at earliest N+1 (combinational slave), done at N+2. done is never in the request cycle.
- Throughput: the next request is accepted in the IDLE cycle after RESP. Minimum 3 cycles per access.
- lsu_req_i while stalled: ignored, no capture. Illegal for MEM1; the bench asserts it never occurs.
- ack/err outside BUS: ignored.
- Reset mid-cycle (BUS or RESP): cyc/stb drop at the reset edge, no done is emitted, and the captured request is discarded.
- Address and select registers are not checked for alignment; MEM1 handles misalignment.

Optional Feature:
- Macro LSU_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES-1 with no termination, the cycle ends: go to RESP with lsu_err_o = 1, lsu_timeout_o = 1, rdata 0.
  - A real ack/err arriving in that same final cycle takes priority (lsu_timeout_o = 0).
- Undefined:
  - No counter; BUS waits indefinitely.
  - lsu_timeout_o is tied to 0.

Test Plan:
- Load, slave acks 1 cycle after stb with wb_dat_i = 32'hDEADBEEF, addr 32'h0000_1006 -> wb_adr_o = 32'h0000_1004, wb_sel_o = 4'hF, done 1 cycle after ack, lsu_rdata_o = 32'hDEADBEEF, err 0.
- Store: addr 32'h2001, sel 4'b0010, wdata 32'h0000_AB00, ack after 3 wait states -> wb_we_o = 1, wb_sel_o = 4'b0010, outputs stable all 4 BUS cycles, single done pulse, lsu_rdata_o = 0.
- Combinational ack in first BUS cycle -> done exactly 2 cycles after the request cycle; lsu_req_stall_o high for 2 cycles; back-to-back second request accepted the cycle after done.
- wb_err_i and wb_ack_i asserted together -> done with lsu_err_o = 1, lsu_rdata_o = 0.
- rst_i pulsed during BUS with slave stalled -> wb_cyc_o = 0 next cycle, no done, later request completes normally.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave never responds -> stb high exactly 8 cycles, then done with err = 1, timeout = 1. Without the macro -> stall persists for 100+ cycles and lsu_timeout_o stays 0.

Source files
------------

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: MEM1 load/store unit driving single-beat Wishbone B4 classic cycles; optional bus timeout via LSU_BUS_TIMEOUT_EN
module lsu_wb_master #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_wsel_byte_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_req_done_o,
  output logic        lsu_err_o,
  output logic        lsu_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [3:0]  sel_q;
  logic        we_q, err_q, to_q, bus, tmo, term;
  assign bus  = state == BUS;
  assign term = bus & (wb_ack_i | wb_err_i | tmo);
`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i)
    cnt <= (rst_i || !bus) ? '0 : cnt + 1'b1;
  assign tmo = bus & ~wb_ack_i & ~wb_err_i & (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif
  if (RESET_PC_UNUSED != 0) begin : g_reserved
  end
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (lsu_req_i ? BUS : IDLE) :
              state == BUS  ? (term ? RESP : BUS) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      if (state == IDLE && lsu_req_i) begin
        adr_q <= lsu_addr_i & 32'hFFFF_FFFC;
        we_q  <= lsu_we_i;
        sel_q <= lsu_we_i ? lsu_wsel_byte_i : 4'hF;
        dat_q <= lsu_we_i ? lsu_wdata_i : '0;
      end
      // err beats a simultaneous ack; tmo only fires when neither is present
      if (term) begin
        rdata_q <= (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
        err_q   <= wb_err_i | tmo;
        to_q    <= tmo;
      end
    end
  end
  assign lsu_req_stall_o = state != IDLE;
  assign lsu_req_done_o  = state == RESP;
  assign lsu_err_o       = lsu_req_done_o & err_q;
  assign lsu_timeout_o   = lsu_req_done_o & to_q;
  assign lsu_rdata_o     = rdata_q;
  assign wb_cyc_o        = bus;
  assign wb_stb_o        = bus;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;
endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: directed table-driven bench for lsu_wb_master
module tb_lsu_wb_master;
  logic        clk, rst, lsu_req, lsu_we, wb_ack, wb_err;
  logic [31:0] lsu_addr, lsu_wdata, wb_dat_i;
  logic [3:0]  lsu_sel;
  logic        stall, done, err_o, to_o, cyc, stb, we_o;
  logic [31:0] rdata, adr_o, dat_o;
  logic [3:0]  sel_o;
  int n_cmp = 0, n_bad = 0;

  lsu_wb_master #(.TIMEOUT_CYCLES(8), .RESET_PC_UNUSED(0)) dut (
    .clk_i(clk), .rst_i(rst), .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr),
    .lsu_we_i(lsu_we), .lsu_wsel_byte_i(lsu_sel), .lsu_wdata_i(lsu_wdata),
    .lsu_req_stall_o(stall), .lsu_rdata_o(rdata), .lsu_req_done_o(done),
    .lsu_err_o(err_o), .lsu_timeout_o(to_o), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_we_o(we_o), .wb_adr_o(adr_o), .wb_sel_o(sel_o), .wb_dat_o(dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && lsu_req) assert (!stall) else $error("request driven while stalled");

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          wait_n;
    logic        ack;
    logic        err;
    logic [31:0] sdat;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;
  vec_t v[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_done", 32'(done), 0);
    lsu_req = 1; lsu_we = t.we; lsu_addr = t.addr; lsu_sel = t.sel; lsu_wdata = t.wdata;
    @(negedge clk);
    lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_sel = 0; lsu_wdata = 0;
    for (int w = 0; w <= t.wait_n; w++) begin
      chk("bus_cyc", 32'(cyc), 1);
      chk("bus_stb", 32'(stb), 1);
      chk("bus_we", 32'(we_o), 32'(t.we));
      chk("bus_adr", adr_o, t.e_adr);
      chk("bus_sel", 32'(sel_o), 32'(t.e_sel));
      chk("bus_dat", dat_o, t.e_dat);
      chk("bus_done", 32'(done), 0);
      chk("bus_stall", 32'(stall), 1);
      if (w == t.wait_n) begin
        wb_ack = t.ack; wb_err = t.err; wb_dat_i = t.sdat;
      end
      @(negedge clk);
    end
    wb_ack = 0; wb_err = 0; wb_dat_i = 32'h0BAD_0BAD;
    chk("resp_done", 32'(done), 1);
    chk("resp_cyc", 32'(cyc), 0);
    chk("resp_err", 32'(err_o), 32'(t.e_err));
    chk("resp_to", 32'(to_o), 0);
    chk("resp_rdata", rdata, t.e_rdata);
    chk("resp_stall", 32'(stall), 1);
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_stall", 32'(stall), 0);
    chk("post_rdata_hold", rdata, t.e_rdata);
  endtask

  initial begin
    int bad, n_stb;
    v[0] = '{1'b0, 32'h0000_1006, 4'h3, 32'h1111_1111, 1, 1'b1, 1'b0, 32'hDEAD_BEEF,
             32'h0000_1004, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
    v[1] = '{1'b1, 32'h0000_2001, 4'b0010, 32'h0000_AB00, 3, 1'b1, 1'b0, 32'h7777_7777,
             32'h0000_2000, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0};
    v[2] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0, 0, 1'b1, 1'b0, 32'h1234_5678,
             32'h0000_0008, 4'hF, 32'h0, 32'h1234_5678, 1'b0};
    v[3] = '{1'b0, 32'h0000_3003, 4'hF, 32'h0, 0, 1'b1, 1'b1, 32'h5555_AAAA,
             32'h0000_3000, 4'hF, 32'h0, 32'h0, 1'b1};
    v[4] = '{1'b1, 32'h0000_0400, 4'hF, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'hFFFF_FFFF,
             32'h0000_0400, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    v[5] = '{1'b1, 32'h8000_0002, 4'b1100, 32'hAB12_0000, 2, 1'b0, 1'b1, 32'h9999_9999,
             32'h8000_0000, 4'b1100, 32'hAB12_0000, 32'h0, 1'b1};
    rst = 1; lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_sel = 0; lsu_wdata = 0;
    wb_ack = 0; wb_err = 0; wb_dat_i = 32'hFEED_FACE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_to", 32'(to_o), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", 32'(stall), 0);
    rst = 0;
    @(negedge clk);
    // back-to-back: each run starts in the IDLE cycle right after the previous done
    for (int i = 0; i < 6; i++) run(v[i]);
    // stray ack/err while idle must not start or finish anything
    wb_ack = 1; wb_err = 1;
    @(negedge clk);
    wb_ack = 0; wb_err = 0;
    chk("stray_done", 32'(done), 0);
    chk("stray_cyc", 32'(cyc), 0);
    run(v[2]);
    // reset while the slave stalls in BUS
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_5000;
    @(negedge clk);
    lsu_req = 0;
    chk("mid_bus_cyc", 32'(cyc), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_cyc", 32'(cyc), 0);
    chk("mid_rst_stb", 32'(stb), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_rdata", rdata, 0);
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done), 0);
    run(v[0]);
    // silent slave
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h0000_0010;
    @(negedge clk);
    lsu_req = 0;
`ifdef LSU_BUS_TIMEOUT_EN
    n_stb = 0;
    for (int i = 0; i < 20 && stb; i++) begin
      n_stb++;
      @(negedge clk);
    end
    chk("tmo_stb_cycles", 32'(n_stb), 8);
    chk("tmo_done", 32'(done), 1);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_flag", 32'(to_o), 1);
    chk("tmo_rdata", rdata, 0);
    @(negedge clk);
    chk("tmo_post_stall", 32'(stall), 0);
`else
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (!stall || !stb || to_o || done) bad++;
      @(negedge clk);
    end
    chk("no_tmo_hold", 32'(bad), 0);
    wb_ack = 1; wb_dat_i = 32'h0000_0077;
    @(negedge clk);
    wb_ack = 0;
    chk("no_tmo_done", 32'(done), 1);
    chk("no_tmo_flag", 32'(to_o), 0);
    chk("no_tmo_err", 32'(err_o), 0);
    chk("no_tmo_rdata", rdata, 32'h0000_0077);
    @(negedge clk);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
